// File: rtl/ga_pkg.sv
// Shared types and constants for the GA run sequencer.
// State encoding, LFSR mask and default datapath widths.
package ga_pkg;

  localparam int GEN_W_DEF = 16;
  localparam int FIT_W_DEF = 16;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    SEL,
    XO,
    MUT,
    WB,
    FIN
  } state_t;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] v
  );
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/ga_lfsr32.sv
// 32-bit right-shifting Galois LFSR with seed load.
// A load with step set loads and advances in the same cycle.
module ga_lfsr32
  import ga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] w_fix;
  logic [31:0] w_base;

  // An all-zero seed would lock the LFSR at zero.
  assign w_fix  = (load_val == 32'h0) ? 32'h1 : load_val;
  assign w_base = load ? w_fix : q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 32'h1;
    end else if (load || step) begin
      q <= step ? lfsr_next(w_base) : w_base;
    end
  end

endmodule

// File: rtl/ga_sequencer.sv
// Generation sequencer for a GA engine: runs eval/sel/xo/mut
// stages with a per-stage watchdog and a PRNG seed per stage.
module ga_sequencer
  import ga_pkg::*;
#(
  parameter int GEN_W   = GEN_W_DEF,
  parameter int FIT_W   = FIT_W_DEF,
  parameter int MAX_GEN = 100,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      seed,
  input  logic [FIT_W-1:0] target_fit,
  output logic             eval_start,
  output logic             sel_start,
  output logic             xo_start,
  output logic             mut_start,
  input  logic             eval_done,
  input  logic             sel_done,
  input  logic             xo_done,
  input  logic             mut_done,
  input  logic [FIT_W-1:0] best_fit,
  output logic [31:0]      stage_seed,
  output logic             pop_we,
  output logic [GEN_W-1:0] gen,
  output logic             busy,
  output logic             finished,
  output logic             hit,
  output logic             timeout_err,
  output logic [FIT_W-1:0] best_q
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [FIT_W-1:0] r_target;
  logic             w_to;
  logic             w_hit;
  logic             w_tmo;
  logic             w_stage;
  logic             w_load;
  logic             w_step;

  assign w_to    = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_stage = w_nxt inside {EVAL, SEL, XO, MUT};
  assign w_load  = (r_state == IDLE) && run;
  assign w_step  = w_stage && (w_nxt != r_state);

  always_comb begin
    w_nxt = r_state;
    w_hit = 1'b0;
    w_tmo = 1'b0;
    unique case (r_state)
      IDLE: if (run) w_nxt = EVAL;
      EVAL: begin
        if (eval_done) begin
          if (best_fit >= r_target) begin
            w_nxt = FIN;
            w_hit = 1'b1;
          end else if (gen == GEN_W'(MAX_GEN)) begin
            w_nxt = FIN;
          end else begin
            w_nxt = SEL;
          end
        end else if (w_to) begin
          w_nxt = FIN;
          w_tmo = 1'b1;
        end
      end
      SEL: begin
        if (sel_done) w_nxt = XO;
        else if (w_to) begin
          w_nxt = FIN;
          w_tmo = 1'b1;
        end
      end
      XO: begin
        if (xo_done) w_nxt = MUT;
        else if (w_to) begin
          w_nxt = FIN;
          w_tmo = 1'b1;
        end
      end
      MUT: begin
        if (mut_done) w_nxt = WB;
        else if (w_to) begin
          w_nxt = FIN;
          w_tmo = 1'b1;
        end
      end
      WB:      w_nxt = EVAL;
      FIN:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_target    <= '0;
      eval_start  <= 1'b0;
      sel_start   <= 1'b0;
      xo_start    <= 1'b0;
      mut_start   <= 1'b0;
      pop_we      <= 1'b0;
      finished    <= 1'b0;
      busy        <= 1'b0;
      hit         <= 1'b0;
      timeout_err <= 1'b0;
      gen         <= '0;
      best_q      <= '0;
    end else begin
      r_state    <= w_nxt;
      eval_start <= (w_nxt == EVAL);
      sel_start  <= (w_nxt == SEL);
      xo_start   <= (w_nxt == XO);
      mut_start  <= (w_nxt == MUT);
      pop_we     <= (w_nxt == WB);
      finished   <= (w_nxt == FIN);
      busy       <= (w_nxt != IDLE);
      if (!w_stage || (w_nxt != r_state)) r_cnt <= '0;
      else                                r_cnt <= r_cnt + 1'b1;
      if (w_load) begin
        r_target    <= target_fit;
        gen         <= '0;
        hit         <= 1'b0;
        timeout_err <= 1'b0;
        best_q      <= '0;
      end
      if ((r_state == EVAL) && eval_done) best_q <= best_fit;
      if (r_state == WB) gen <= gen + 1'b1;
      if (w_hit) hit <= 1'b1;
      if (w_tmo) timeout_err <= 1'b1;
    end
  end

  ga_lfsr32 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (seed),
    .step     (w_step),
    .q        (stage_seed)
  );

endmodule
